anc_fir_ctrl: RTL

- Initiator side of the FIR go/done handshake: turns the reference-mic and error-mic sample streams into one FIR frame per reference sample.
- Per frame it latches x, a and the LMS step weight_adjust = mu·e, pulses fir_go, waits for done, and forwards the result to the DAC.
- Sits between the ADC/DAC sample interfaces and the fir block.
- Buffers one early reference sample and flags overruns.

---
 rtl/anc_pkg.sv | 9 +
 rtl/anc_mu_scale.sv | 20 ++
 rtl/anc_fir_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/anc_pkg.sv
// anc_pkg: shared widths, FIR-controller state encoding and Q1.15 saturation
package anc_pkg;
  localparam int SAMPLE_W = 16;
  localparam int Q_FRAC = 15;
  typedef enum logic [2:0] {IDLE, WAIT_IDLE, GO, BUSY, OUT} state_t;
  function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
    return (v > 32'sd32767) ? 16'h7fff : (v < -32'sd32768) ? 16'h8000 : v[15:0];
  endfunction
endpackage

// File: rtl/anc_mu_scale.sv
// anc_mu_scale: LMS step e*mu rescaled to Q1.15 with saturation and adapt gate
module anc_mu_scale
  import anc_pkg::*;
#(
  parameter int MU_W = 16
) (
  input  logic [SAMPLE_W-1:0] e,
  input  logic [MU_W-1:0]     mu,
  input  logic                en,
  output logic [SAMPLE_W-1:0] wadj
);
  logic signed [SAMPLE_W+MU_W-1:0] p;
  logic signed [SAMPLE_W+MU_W-1:0] q;
  // full-precision product, drop the Q_FRAC fraction bits, clamp to 16 bits
  always_comb begin
    p = $signed(e) * $signed(mu);
    q = p >>> Q_FRAC;
    wadj = en ? sat16(32'(q)) : '0;
  end
endmodule

// File: rtl/anc_fir_ctrl.sv
// anc_fir_ctrl: launches one FIR frame per reference sample and forwards results to the DAC
module anc_fir_ctrl
  import anc_pkg::*;
#(
  parameter int MU_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] ref_sample,
  input  logic                ref_valid,
  input  logic [SAMPLE_W-1:0] add_sample,
  input  logic [SAMPLE_W-1:0] err_sample,
  input  logic                err_valid,
  input  logic [MU_W-1:0]     mu_gain,
  input  logic                adapt_en,
  input  logic                ovr_clr,
  output logic [SAMPLE_W-1:0] fir_x,
  output logic [SAMPLE_W-1:0] fir_a,
  output logic [SAMPLE_W-1:0] fir_wadj,
  output logic                fir_go,
  input  logic                fir_done,
  input  logic [SAMPLE_W-1:0] fir_out,
  input  logic                fir_act,
  output logic [SAMPLE_W-1:0] dac_sample,
  output logic                dac_valid,
  output logic                busy,
  output logic                overrun,
  output logic [CNT_W-1:0]    frame_cnt
);
  state_t state;
  logic [SAMPLE_W-1:0] err_hold, e, wadj, pend_x, pend_a, l_x, l_a;
  logic pend_v, launch_ref, launch_pend, launch, store, set_ovr;
  // a fresh error sample in the decision cycle beats the held one
  assign e = err_valid ? err_sample : err_hold;
  anc_mu_scale #(.MU_W(MU_W)) u_mu (.e(e), .mu(mu_gain), .en(adapt_en), .wadj(wadj));
  // pending pair launches first whenever the controller is free; a fresh ref goes direct only if nothing waits
  assign launch_pend = pend_v && (state == IDLE || state == OUT);
  assign launch_ref = ref_valid && state == IDLE && !pend_v;
  assign launch = launch_ref || launch_pend;
  assign l_x = launch_pend ? pend_x : ref_sample;
  assign l_a = launch_pend ? pend_a : add_sample;
  assign store = ref_valid && !launch_ref;
  assign set_ovr = ref_valid && pend_v && !launch_pend;
  assign busy = state inside {WAIT_IDLE, GO, BUSY};
  // frame sequencing, pending buffer, overrun flag and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      err_hold <= '0;
      pend_v <= 1'b0;
      pend_x <= '0;
      pend_a <= '0;
      fir_x <= '0;
      fir_a <= '0;
      fir_wadj <= '0;
      fir_go <= 1'b0;
      dac_sample <= '0;
      dac_valid <= 1'b0;
      overrun <= 1'b0;
      frame_cnt <= '0;
    end else begin
      fir_go <= 1'b0;
      dac_valid <= 1'b0;
      if (err_valid) err_hold <= err_sample;
      overrun <= set_ovr || (overrun && !ovr_clr);
      if (store) begin
        pend_x <= ref_sample;
        pend_a <= add_sample;
      end
      pend_v <= store || (pend_v && !launch_pend);
      if (launch) begin
        fir_x <= l_x;
        fir_a <= l_a;
        fir_wadj <= wadj;
        state <= fir_act ? WAIT_IDLE : GO;
        fir_go <= !fir_act;
      end else begin
        case (state)
          WAIT_IDLE: if (!fir_act) begin
            state <= GO;
            fir_go <= 1'b1;
          end
          GO: state <= BUSY;
          BUSY: if (fir_done) begin
            dac_sample <= fir_out;
            dac_valid <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
            state <= OUT;
          end
          OUT: state <= IDLE;
          default: ;
        endcase
      end
    end
  end
endmodule
